// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the architectural PC. Fetches one instruction word over a req/ack
// instruction-memory port, presents it with its PC to the decode/control
// stage, then computes the next PC from the controller's selection once
// the datapath signals that the current instruction is done.
//
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous active-high reset
//   o_imemAddr    instruction memory address (held stable while requesting)
//   o_imemReq     instruction memory request
//   i_imemAck     memory ack; i_imemData valid in the same cycle
//   i_imemData    instruction word from memory
//   i_pcNextSel   00/11 = PC+4, 01 = PC+offset, 10 = (rs1+offset) & ~1
//   i_offset      sign-extended branch/jump immediate
//   i_rs1Data     rs1 value for indirect jumps
//   i_advance     datapath finished the current instruction
//   o_inst        current instruction word
//   o_instPC      PC of o_inst
//   o_instValid   o_inst / o_instPC valid
//   o_misaligned  sticky: computed next PC was not 4-byte aligned
//   o_timeout     sticky: ack not received within MAX_WAIT cycles
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         MAX_WAIT = 255
) (
  input  logic                i_clock,
  input  logic                i_reset,
  output logic [PC_WIDTH-1:0] o_imemAddr,
  output logic                o_imemReq,
  input  logic                i_imemAck,
  input  logic [31:0]         i_imemData,
  input  logic [1:0]          i_pcNextSel,
  input  logic [PC_WIDTH-1:0] i_offset,
  input  logic [PC_WIDTH-1:0] i_rs1Data,
  input  logic                i_advance,
  output logic [31:0]         o_inst,
  output logic [PC_WIDTH-1:0] o_instPC,
  output logic                o_instValid,
  output logic                o_misaligned,
  output logic                o_timeout
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  // Counter value seen in the last permitted wait cycle; the edge that ends
  // that cycle is the one where the count would reach MAX_WAIT.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         wait_cnt;
  logic [PC_WIDTH-1:0] next_pc;

  // Next-PC selection; all sums wrap modulo 2^PC_WIDTH.
  always_comb begin
    next_pc = pc + PC_WIDTH'(4);
    case (i_pcNextSel)
      2'b01:   next_pc = pc + i_offset;
      2'b10:   next_pc = (i_rs1Data + i_offset) & {{(PC_WIDTH-1){1'b1}}, 1'b0};
      default: next_pc = pc + PC_WIDTH'(4);
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= S_RESET;
      pc           <= RESET_PC;
      wait_cnt     <= '0;
      o_imemReq    <= 1'b0;
      o_imemAddr   <= RESET_PC;
      o_inst       <= NOP;
      o_instPC     <= RESET_PC;
      o_instValid  <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state      <= S_FETCH;
          o_imemReq  <= 1'b1;
          o_imemAddr <= pc;
          wait_cnt   <= '0;
        end

        S_FETCH: begin
          if (i_imemAck) begin
            o_inst      <= i_imemData;
            o_instPC    <= pc;
            o_instValid <= 1'b1;
            o_imemReq   <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            o_timeout <= 1'b1;
            o_imemReq <= 1'b0;
            state     <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_HOLD: begin
          if (i_advance) begin
            o_instValid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              o_misaligned <= 1'b1;
              state        <= S_FAULT;
            end else begin
              pc         <= next_pc;
              o_imemReq  <= 1'b1;
              o_imemAddr <= next_pc;
              wait_cnt   <= '0;
              state      <= S_FETCH;
            end
          end
        end

        default: begin
          // Terminal fault: everything holds until reset.
          o_imemReq   <= 1'b0;
          o_instValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Produces the instruction word and its PC consumed by the datapath controller, then consumes the controller's PC-next selection to compute the following fetch address.
- Sits between the instruction memory port and the decode/control stage.
- Owns the architectural PC.
- Handles variable-latency instruction memory with a req/ack handshake, a wait-timeout, and misaligned-target detection.

Parameters:
PC_WIDTH, 32, width of PC, addresses and offsets
RESET_PC, 0, PC loaded on reset
MAX_WAIT, 255, cycles a request may wait for ack before fault (1..2^16-1)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  synchronous reset, active-high
o_imemAddr  out  PC_WIDTH  instruction memory address
o_imemReq  out  1  instruction memory request
i_imemAck  in  1  memory ack; i_imemData valid this cycle
i_imemData  in  32  instruction word from memory
i_pcNextSel  in  2  00=PC+4, 01=PC+offset, 10=(rs1+offset)&~1, 11=treated as 00
i_offset  in  PC_WIDTH  sign-extended branch/jump immediate
i_rs1Data  in  PC_WIDTH  RS1 value for indirect jumps
i_advance  in  1  datapath finished current instruction
o_inst  out  32  current instruction
o_instPC  out  PC_WIDTH  PC of o_inst
o_instValid  out  1  o_inst/o_instPC valid
o_misaligned  out  1  sticky: next PC not 4-byte aligned
o_timeout  out  1  sticky: ack not received within MAX_WAIT cycles

Behaviour:
- Reset values: pc=RESET_PC; o_imemReq=0; o_imemAddr=RESET_PC; o_inst=32'h00000013 (NOP); o_instPC=RESET_PC; o_instValid=0; o_misaligned=0; o_timeout=0; wait counter=0; state=sRESET.
- Reset has priority over all other inputs in the same cycle. Reset mid-fetch drops o_imemReq at the next edge. An ack arriving after reset is ignored.
- States: sRESET, sFETCH, sHOLD, sFAULT.
- sRESET: one cycle, then go to sFETCH.
- sFETCH:
  - o_imemReq=1 and o_imemAddr=pc, both held stable until ack.
  - Ack may arrive in the same cycle req first goes high (zero-wait memory).
  - On i_imemAck: at the edge, o_inst<=i_imemData, o_instPC<=pc, o_instValid<=1, req<=0, counter<=0; go to sHOLD.
  - No ack: counter increments. If counter reaches MAX_WAIT without ack, at that edge: o_timeout<=1, req<=0; go to sFAULT.
  - o_instValid=0 throughout.
- sHOLD:
  - o_instValid=1; o_inst and o_instPC held stable.
  - On i_advance, compute next from pc, modulo 2^PC_WIDTH (wrap, no carry out): sel 00/11 -> pc+4; 01 -> pc+i_offset; 10 -> (i_rs1Data+i_offset) with bit0 cleared.
  - If next[1:0]!=0: o_misaligned<=1, o_instValid<=0; go to sFAULT; pc unchanged.
  - Else: pc<=next, o_instValid<=0; go to sFETCH. Req rises the cycle after advance.
- sFAULT: terminal until reset. o_imemReq=0, o_instValid=0; sticky flags hold; all inputs ignored.
- Ignored inputs: i_advance outside sHOLD; i_imemAck outside sFETCH.
- Latency: ack at cycle N -> o_instValid=1 at N+1. i_advance at M -> o_imemReq=1 with the new address at M+1. Zero-wait memory sustains 1 instruction per 2 cycles.
- i_pcNextSel, i_offset and i_rs1Data are sampled only in the advance cycle.

Test Plan:
1. Reset release with RESET_PC=0, ack tied 1, data=0x00500093 -> req=1 addr=0 at cycle 1; instValid=1 at cycle 2 with inst=0x00500093, instPC=0.
2. Sequential run: 4 advances with sel=00, zero-wait memory -> addresses 0,4,8,C; instValid alternates each cycle; instPC matches each address.
3. Branch: at PC=0x10, sel=01, offset=0xFFFFFFF8 -> next req addr=0x08. JALR: sel=10, rs1=0x101, offset=0 -> addr=0x100 (bit0 cleared).
4. Misaligned: sel=01, offset=0x6 at PC=0 -> o_misaligned=1, instValid=0, no further req; hold 20 cycles with advance/ack toggling -> no change until reset.
5. Wait states: ack delayed 3 cycles -> addr stable for all 4 req cycles, instValid 1 cycle after ack. MAX_WAIT=8 with no ack -> o_timeout=1 and req=0 after the 8th wait cycle.
6. Reset mid-fetch: reset during req with ack arriving the following cycle -> req=0, instValid=0, pc=RESET_PC; ack ignored; new fetch at RESET_PC two cycles after reset drops.
